// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall, flush and forwarding control for the 5-stage CPU.
// Resolves load-use stalls, taken-branch squashes and multi-cycle IO waits
// (with a timeout that sets a sticky io_err), and selects operand bypasses.
// Optional macro HAZARD_STALL_CNT_EN adds a saturating stall_cnt output that
// counts cycles in which the PC/IF-ID are held.
module pipe_hazard_ctrl #(
    parameter int IO_TIMEOUT = 16,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic             use_rs,
    input  logic             use_rt,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [4:0]       ern,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic [4:0]       mrn,
    input  logic             branch_taken,
    input  logic             io_req,
    input  logic             io_ready,
    output logic             wpcir,
    output logic             dbubble,
    output logic             ebubble,
    output logic             freeze,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             io_err
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    typedef enum logic {
        S_RUN     = 1'b0,
        S_IO_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_io_err;
    logic [8:0]  w_cnt_nxt;
    logic        w_lu;
    logic        w_io_stall;
    logic        w_timeout;

    // Bypass select for one source operand; the younger EX result wins.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       e_wreg,
        input logic       e_m2reg,
        input logic [4:0] e_rn,
        input logic       m_wreg,
        input logic       m_m2reg,
        input logic [4:0] m_rn
    );
        if (e_wreg && !e_m2reg && (e_rn != 5'd0) && (e_rn == src))
            return 2'd1;
        else if (m_wreg && !m_m2reg && (m_rn != 5'd0) && (m_rn == src))
            return 2'd2;
        else if (m_wreg && m_m2reg && (m_rn != 5'd0) && (m_rn == src))
            return 2'd3;
        else
            return 2'd0;
    endfunction

    assign fwda = fwd_sel(rs, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
    assign fwdb = fwd_sel(rt, ewreg, em2reg, ern, mwreg, mm2reg, mrn);

    // A load in EX whose destination is read by the ID instruction.
    assign w_lu = ewreg && em2reg && (ern != 5'd0) &&
                  ((use_rs && (ern == rs)) || (use_rt && (ern == rt)));

    // The stall starts in the very cycle the IO access is seen not ready.
    assign w_io_stall = (r_state == S_IO_WAIT) || (io_req && !io_ready);

    // Counter value after this cycle; it reaches IO_TIMEOUT on the last frozen cycle.
    assign w_cnt_nxt = {1'b0, r_cnt} + 9'd1;
    assign w_timeout = (w_cnt_nxt >= 9'(IO_TIMEOUT));

    assign io_err = r_io_err;

    // Stall/flush controls; IO stall outranks load-use, which outranks branch squash.
    always_comb begin
        wpcir   = 1'b1;
        dbubble = 1'b0;
        ebubble = 1'b0;
        freeze  = 1'b0;
        if (resetn) begin
            if (w_io_stall) begin
                wpcir  = 1'b0;
                freeze = 1'b1;
            end else if (w_lu) begin
                wpcir   = 1'b0;
                ebubble = 1'b1;
            end else if (branch_taken) begin
                dbubble = 1'b1;
            end
        end
    end

    // IO wait sequencer with timeout counter and sticky error flag.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_RUN;
            r_cnt    <= 8'd0;
            r_io_err <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (io_req && !io_ready) begin
                        r_state <= S_IO_WAIT;
                        r_cnt   <= 8'd1;
                    end
                end
                S_IO_WAIT: begin
                    if (io_ready) begin
                        r_state <= S_RUN;
                        r_cnt   <= 8'd0;
                    end else if (w_timeout) begin
                        r_state  <= S_RUN;
                        r_cnt    <= 8'd0;
                        r_io_err <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_nxt[7:0];
                    end
                end
                default: begin
                    r_state <= S_RUN;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    assign stall_cnt = r_stall_cnt;

    // Count held-PC cycles, sticking at all-ones instead of wrapping.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            r_stall_cnt <= '0;
        else if (!wpcir && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, load-use, branch squash,
// IO wait, IO timeout and reset behaviour.
module tb_pipe_hazard_ctrl;

    logic        clock = 1'b0;
    logic        resetn;
    logic [4:0]  rs, rt, ern, mrn;
    logic        use_rs, use_rt, ewreg, em2reg, mwreg, mm2reg;
    logic        branch_taken, io_req, io_ready;
    logic        wpcir, dbubble, ebubble, freeze, io_err;
    logic [1:0]  fwda, fwdb;
`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] stall_base;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.IO_TIMEOUT(16), .CNT_W(16)) dut (
        .clock(clock), .resetn(resetn),
        .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
        .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
        .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn),
        .branch_taken(branch_taken), .io_req(io_req), .io_ready(io_ready),
        .wpcir(wpcir), .dbubble(dbubble), .ebubble(ebubble), .freeze(freeze),
        .fwda(fwda), .fwdb(fwdb), .io_err(io_err)
`ifdef HAZARD_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the four stall/flush controls together.
    task automatic chk_ctl(input string tag, input logic w, input logic db,
                           input logic eb, input logic fz);
        chk({tag, ".wpcir"}, 32'(wpcir), 32'(w));
        chk({tag, ".dbubble"}, 32'(dbubble), 32'(db));
        chk({tag, ".ebubble"}, 32'(ebubble), 32'(eb));
        chk({tag, ".freeze"}, 32'(freeze), 32'(fz));
    endtask

    task automatic clear_inputs();
        rs = 0; rt = 0; ern = 0; mrn = 0;
        use_rs = 0; use_rt = 0; ewreg = 0; em2reg = 0; mwreg = 0; mm2reg = 0;
        branch_taken = 0; io_req = 0; io_ready = 0;
    endtask

    // Move to the next cycle's drive point, just after the rising edge.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        clear_inputs();
        resetn = 1'b0;

        // Reset with idle inputs, then with an IO request pending.
        @(negedge clock);
        chk_ctl("reset_idle", 1, 0, 0, 0);
        chk("reset_fwda", 32'(fwda), 0);
        chk("reset_fwdb", 32'(fwdb), 0);
        chk("reset_io_err", 32'(io_err), 0);
        io_req = 1;
        #1;
        chk_ctl("reset_ioreq", 1, 0, 0, 0);
        next_cycle();
        io_req = 0;
        resetn = 1'b1;

        // Forwarding: EX beats MEM, then MEM ALU, MEM load, and r0 never forwards.
        ewreg = 1; em2reg = 0; ern = 5; rs = 5; mwreg = 1; mm2reg = 0; mrn = 5; rt = 7;
        @(negedge clock);
        chk("fwd_ex_prio", 32'(fwda), 1);
        chk("fwd_b_none", 32'(fwdb), 0);
        chk_ctl("fwd_no_stall", 1, 0, 0, 0);
        next_cycle();
        ewreg = 0;
        @(negedge clock);
        chk("fwd_mem_alu", 32'(fwda), 2);
        next_cycle();
        mm2reg = 1; rt = 5;
        @(negedge clock);
        chk("fwd_mem_load_a", 32'(fwda), 3);
        chk("fwd_mem_load_b", 32'(fwdb), 3);
        next_cycle();
        ewreg = 1; ern = 0; rs = 0; mrn = 0; rt = 0;
        @(negedge clock);
        chk("fwd_r0_a", 32'(fwda), 0);
        chk("fwd_r0_b", 32'(fwdb), 0);
        next_cycle();
        clear_inputs();

        // Load-use on rt with a taken branch: stall wins, branch ignored.
        ewreg = 1; em2reg = 1; ern = 8; rt = 8; use_rt = 1; branch_taken = 1;
        @(negedge clock);
        chk_ctl("lu_stall", 0, 0, 1, 0);
        next_cycle();
        ewreg = 0; branch_taken = 0;
        @(negedge clock);
        chk_ctl("lu_release", 1, 0, 0, 0);
        next_cycle();
        ewreg = 1; use_rt = 0;
        @(negedge clock);
        chk_ctl("lu_unused_rt", 1, 0, 0, 0);
        next_cycle();
        clear_inputs();
        ewreg = 1; em2reg = 1; ern = 3; rs = 3; use_rs = 1;
        @(negedge clock);
        chk_ctl("lu_rs", 0, 0, 1, 0);
        next_cycle();
        clear_inputs();

        // Branch squash lasts only the cycle it is asserted.
        branch_taken = 1;
        @(negedge clock);
        chk_ctl("br_squash", 1, 1, 0, 0);
        next_cycle();
        branch_taken = 0;
        @(negedge clock);
        chk_ctl("br_done", 1, 0, 0, 0);
        next_cycle();

        // IO wait: 3 not-ready cycles then ready -> 4 frozen cycles.
        io_req = 1; io_ready = 0; branch_taken = 1;
        ewreg = 1; em2reg = 1; ern = 9; rs = 9; use_rs = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk_ctl($sformatf("io_wait%0d", i), 0, 0, 0, 1);
            next_cycle();
        end
        clear_inputs();
        io_req = 1; io_ready = 1;
        @(negedge clock);
        chk_ctl("io_ready_cycle", 0, 0, 0, 1);
        next_cycle();
        io_req = 0; io_ready = 0;
        @(negedge clock);
        chk_ctl("io_back_run", 1, 0, 0, 0);
        chk("io_no_err", 32'(io_err), 0);
        next_cycle();

        // IO timeout: exactly 16 frozen cycles, then io_err sticks.
`ifdef HAZARD_STALL_CNT_EN
        stall_base = stall_cnt;
`endif
        io_req = 1; io_ready = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            chk($sformatf("to_freeze%0d", i), 32'(freeze), 1);
            next_cycle();
        end
        io_req = 0;
        @(negedge clock);
        chk_ctl("to_released", 1, 0, 0, 0);
        chk("to_io_err", 32'(io_err), 1);
`ifdef HAZARD_STALL_CNT_EN
        chk("to_stall_cnt", 32'(stall_cnt - stall_base), 16);
`endif
        next_cycle();
        next_cycle();
        @(negedge clock);
        chk("io_err_sticky", 32'(io_err), 1);
        next_cycle();

        // Reset mid IO_WAIT returns to RUN at once and clears io_err.
        io_req = 1;
        next_cycle();
        next_cycle();
        io_req = 0;
        @(negedge clock);
        chk("mid_wait_frozen", 32'(freeze), 1);
        resetn = 1'b0;
        #1;
        chk_ctl("mid_reset", 1, 0, 0, 0);
        chk("mid_reset_err", 32'(io_err), 0);
        next_cycle();
        resetn = 1'b1;
        @(negedge clock);
        chk_ctl("after_reset_run", 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and stall controller for the 5-stage pipelined CPU with memory-mapped IO. It drives the stall and flush controls consumed by the PC register and the IF/ID pipeline register (wpcir, dbubble), the ID/EX bubble, and the operand-forwarding selects. It sequences multi-cycle IO waits with a small state machine and a timeout counter. It sits beside the ID stage and observes the ID, EX and MEM stage register-write information.

Parameters:
IO_TIMEOUT, 16, maximum IO_WAIT cycles before forced release (valid range 1..255)
CNT_W, 16, width of the optional stall performance counter

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
rs  in  5  ID-stage source register A
rt  in  5  ID-stage source register B
use_rs  in  1  ID instruction reads rs
use_rt  in  1  ID instruction reads rt
ewreg  in  1  EX instruction writes the register file
em2reg  in  1  EX instruction is a load
ern  in  5  EX destination register
mwreg  in  1  MEM instruction writes the register file
mm2reg  in  1  MEM instruction is a load
mrn  in  5  MEM destination register
branch_taken  in  1  ID-stage branch or jump resolved taken
io_req  in  1  MEM-stage access targets the IO region
io_ready  in  1  IO device completes the access this cycle
wpcir  out  1  1 = PC and IF/ID load; 0 = hold
dbubble  out  1  1 = IF/ID loads zero (nop)
ebubble  out  1  1 = ID/EX loads nop
freeze  out  1  1 = ID/EX, EX/MEM and MEM/WB hold
fwda  out  2  rs operand select: 0 reg file, 1 EX ALU, 2 MEM ALU, 3 MEM load data
fwdb  out  2  rt operand select: same encoding
io_err  out  1  sticky: an IO timeout occurred

Behaviour:
- States: RUN, IO_WAIT. Reset -> RUN, timeout counter = 0, io_err = 0.
- Output values during reset: wpcir=1, dbubble=0, ebubble=0, freeze=0, io_err=0. fwda and fwdb are purely combinational.
- Forwarding (combinational, same encoding for rt/fwdb):
  - fwda=1 if ewreg & ~em2reg & ern!=0 & ern==rs.
  - Otherwise fwda=2 if mwreg & ~mm2reg & mrn!=0 & mrn==rs.
  - Otherwise fwda=3 if mwreg & mm2reg & mrn!=0 & mrn==rs.
  - Otherwise fwda=0.
  - The EX match takes priority over the MEM match.
- Load-use hazard: lu = ewreg & em2reg & ern!=0 & ((use_rs & ern==rs) | (use_rt & ern==rt)).
- RUN, io_req & ~io_ready:
  - Next state is IO_WAIT and the counter loads 1.
  - The same cycle already outputs wpcir=0, freeze=1, ebubble=0, dbubble=0.
- RUN, otherwise:
  - If lu: wpcir=0, ebubble=1, dbubble=0 (single-cycle stall; branch_taken is ignored).
  - Else if branch_taken: wpcir=1, dbubble=1 (squash the fetched instruction).
  - Else: wpcir=1, all other outputs 0.
- IO_WAIT:
  - Outputs wpcir=0, freeze=1, ebubble=0, dbubble=0; the counter increments each cycle.
  - On io_ready=1: outputs stay frozen that cycle and the state returns to RUN next cycle.
  - On counter==IO_TIMEOUT with no io_ready: io_err is set, the state returns to RUN next cycle, and the access is treated as complete.
- Priority: IO stall > load-use > branch flush.
- wpcir=0 and dbubble=1 are never asserted together.
- Reset asserted mid-IO_WAIT returns to RUN immediately.
- io_err clears only on reset.

Optional Feature:
Macro HAZARD_STALL_CNT_EN.
- Defined: adds output stall_cnt [CNT_W-1:0]. It resets to 0 and increments on every cycle where wpcir=0, saturating at all-ones (no wrap).
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset, idle inputs -> wpcir=1, dbubble=0, ebubble=0, freeze=0, fwda=fwdb=0, io_err=0.
- ewreg=1, em2reg=0, ern=5, rs=5, and mwreg=1, mrn=5 -> fwda=1 (EX priority). ern=0, rs=0 -> fwda=0.
- ewreg=1, em2reg=1, ern=8, rt=8, use_rt=1, branch_taken=1 -> one cycle of wpcir=0, ebubble=1, dbubble=0. Next cycle with ewreg=0 -> wpcir=1.
- branch_taken=1, no hazard -> dbubble=1, wpcir=1 for exactly that cycle.
- io_req=1, io_ready=0 for 3 cycles, then io_ready=1 -> freeze=1 and wpcir=0 for 4 cycles, RUN on the 5th cycle, io_err stays 0.
- io_ready held 0 with IO_TIMEOUT=16 -> exactly 16 frozen cycles, io_err=1 and sticky. With HAZARD_STALL_CNT_EN defined, stall_cnt=16.
